// File: rtl/lcd_pkg.sv
// LCD init sequencer shared definitions.
// Holds the init-ROM opcode encoding, the sequencer state encoding and the
// 9-bit word presented to the write-path mux ({wr_n, data}).
package lcd_pkg;

    typedef enum logic [1:0] {
        OP_CMD   = 2'b00,
        OP_DATA  = 2'b01,
        OP_DELAY = 2'b10,
        OP_END   = 2'b11
    } opcode_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HWRST_LO,
        S_HWRST_WAIT,
        S_FETCH,
        S_DECODE,
        S_WR_LO,
        S_WR_HI,
        S_DELAY,
        S_DONE
    } state_t;

    typedef struct packed {
        logic       wr_n;
        logic [7:0] data;
    } lcd_word_t;

    // Bus parked: WR high, data zero.
    localparam lcd_word_t LCD_WORD_IDLE = 9'h100;

endpackage

// File: rtl/lcd_ms_timer.sv
// Loadable down-counter used for the hardware-reset phases and ROM delays.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (count cleared)
//   i_load      - load i_load_val (takes priority over i_dec)
//   i_load_val  - value to load
//   i_dec       - decrement by one, saturating at zero
//   o_done      - count is zero
module lcd_ms_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/lcd_init_seq.sv
// LCD init sequencer: walks an init ROM of CMD/DATA/DELAY/END entries and
// drives the ROM side of the LCD write-path mux ({WR_n, data}), the D/C line
// and the LCD hardware reset. init_done hands the bus to the MCU path.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   start       - single-cycle pulse, accepted only in IDLE or DONE
//   rom_addr    - init ROM address (ROM has 1-cycle read latency)
//   rom_data    - ROM word: [9:8] opcode, [7:0] payload
//   lcd_word    - [8] WR active low, [7:0] data
//   lcd_dc      - 0 = command, 1 = data
//   lcd_rst_n   - LCD hardware reset, active low
//   busy        - sequence in progress
//   init_done   - mux select, 1 = MCU path
// Build option: define LCD_HWRST_EN to run a hardware-reset pulse and
// post-reset wait before the ROM walk; otherwise lcd_rst_n is tied high.
module lcd_init_seq
    import lcd_pkg::*;
#(
    parameter int ROM_AW      = 6,
    parameter int CLK_HZ      = 50_000_000,
    parameter int MS_CYC      = CLK_HZ / 1000,
    parameter int WR_LO_CYC   = 4,
    parameter int WR_HI_CYC   = 4,
    parameter int RST_LO_MS   = 10,
    parameter int RST_WAIT_MS = 120
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [9:0]        rom_data,
    output logic [8:0]        lcd_word,
    output logic              lcd_dc,
    output logic              lcd_rst_n,
    output logic              busy,
    output logic              init_done
);

`ifdef LCD_HWRST_EN
    localparam bit HWRST_EN = 1'b1;
`else
    localparam bit HWRST_EN = 1'b0;
`endif
    localparam int RST_MAX_MS = (RST_LO_MS > RST_WAIT_MS) ? RST_LO_MS : RST_WAIT_MS;
    localparam int CNT_MAX    = 255 * MS_CYC + (HWRST_EN ? RST_MAX_MS * MS_CYC : 0);
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int WR_MAX     = (WR_LO_CYC > WR_HI_CYC) ? WR_LO_CYC : WR_HI_CYC;
    localparam int WR_W       = $clog2(WR_MAX + 1);

    state_t            r_state, w_state_next;
    logic [ROM_AW-1:0] r_addr, w_addr_next;
    lcd_word_t         r_word, w_word_next;
    logic              r_dc, w_dc_next;
    logic              r_busy, w_busy_next;
    logic              r_done, w_done_next;
    logic [WR_W-1:0]   r_wr_cnt, w_wr_cnt_next;

    logic              w_tmr_load, w_tmr_dec, w_tmr_done;
    logic [CNT_W-1:0]  w_tmr_val;
    logic              w_adv, w_finish;
    opcode_t           w_opcode;

    assign w_opcode = opcode_t'(rom_data[9:8]);

    lcd_ms_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_done     (w_tmr_done)
    );

`ifdef LCD_HWRST_EN
    localparam logic [CNT_W-1:0] RST_LO_LOAD   = CNT_W'(RST_LO_MS * MS_CYC - 1);
    localparam logic [CNT_W-1:0] RST_WAIT_LOAD = CNT_W'(RST_WAIT_MS * MS_CYC - 1);
    logic r_rst_n, w_rst_n_next;
`endif

    always_comb begin
        w_state_next  = r_state;
        w_addr_next   = r_addr;
        w_word_next   = r_word;
        w_dc_next     = r_dc;
        w_busy_next   = r_busy;
        w_done_next   = r_done;
        w_wr_cnt_next = r_wr_cnt;
        w_tmr_load    = 1'b0;
        w_tmr_val     = '0;
        w_tmr_dec     = 1'b0;
        w_adv         = 1'b0;
        w_finish      = 1'b0;
`ifdef LCD_HWRST_EN
        w_rst_n_next  = r_rst_n;
`endif
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_addr_next = '0;
                    w_busy_next = 1'b1;
                    w_done_next = 1'b0;
                    w_word_next = LCD_WORD_IDLE;
`ifdef LCD_HWRST_EN
                    // Loaded with N-1: the exit clock itself is the Nth.
                    w_rst_n_next = 1'b0;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = RST_LO_LOAD;
                    w_state_next = S_HWRST_LO;
`else
                    w_state_next = S_FETCH;
`endif
                end
            end
`ifdef LCD_HWRST_EN
            S_HWRST_LO: begin
                if (w_tmr_done) begin
                    w_rst_n_next = 1'b1;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = RST_WAIT_LOAD;
                    w_state_next = S_HWRST_WAIT;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            S_HWRST_WAIT: begin
                if (w_tmr_done) begin
                    w_state_next = S_FETCH;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
`endif
            // Address is stable here; the ROM word is valid in DECODE.
            S_FETCH: w_state_next = S_DECODE;
            S_DECODE: begin
                case (w_opcode)
                    OP_CMD, OP_DATA: begin
                        w_word_next   = '{wr_n: 1'b0, data: rom_data[7:0]};
                        w_dc_next     = rom_data[8];
                        w_wr_cnt_next = '0;
                        w_state_next  = S_WR_LO;
                    end
                    OP_DELAY: begin
                        w_tmr_load   = 1'b1;
                        w_tmr_val    = CNT_W'(rom_data[7:0]) * CNT_W'(MS_CYC);
                        w_state_next = S_DELAY;
                    end
                    default: w_finish = 1'b1;
                endcase
            end
            S_WR_LO: begin
                if (r_wr_cnt == WR_W'(WR_LO_CYC - 1)) begin
                    w_word_next.wr_n = 1'b1;
                    w_wr_cnt_next    = '0;
                    w_state_next     = S_WR_HI;
                end else begin
                    w_wr_cnt_next = r_wr_cnt + WR_W'(1);
                end
            end
            S_WR_HI: begin
                if (r_wr_cnt == WR_W'(WR_HI_CYC - 1)) begin
                    w_adv = 1'b1;
                end else begin
                    w_wr_cnt_next = r_wr_cnt + WR_W'(1);
                end
            end
            S_DELAY: begin
                if (w_tmr_done) begin
                    w_adv = 1'b1;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        // Last ROM entry acts as an implicit END; the address never wraps.
        if (w_finish || (w_adv && (r_addr == '1))) begin
            w_state_next = S_DONE;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
            w_word_next  = LCD_WORD_IDLE;
        end else if (w_adv) begin
            w_addr_next  = r_addr + ROM_AW'(1);
            w_state_next = S_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_word   <= LCD_WORD_IDLE;
            r_dc     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_wr_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_addr   <= w_addr_next;
            r_word   <= w_word_next;
            r_dc     <= w_dc_next;
            r_busy   <= w_busy_next;
            r_done   <= w_done_next;
            r_wr_cnt <= w_wr_cnt_next;
        end
    end

`ifdef LCD_HWRST_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rst_n <= 1'b1;
        end else begin
            r_rst_n <= w_rst_n_next;
        end
    end
    assign lcd_rst_n = r_rst_n;
`else
    assign lcd_rst_n = 1'b1;
`endif

    assign rom_addr  = r_addr;
    assign lcd_word  = r_word;
    assign lcd_dc    = r_dc;
    assign busy      = r_busy;
    assign init_done = r_done;

endmodule

// File: tb/tb_lcd_init_seq.sv
// Testbench for lcd_init_seq: table-driven ROM programs plus hand-written
// latency, reset-abort, restart and address-boundary sequences.
module tb_lcd_init_seq;

    localparam int MS = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, start2;
    logic [5:0] rom_addr;
    logic [9:0] rom_data;
    logic [8:0] lcd_word;
    logic       lcd_dc, lcd_rst_n, busy, init_done;
    logic [1:0] rom_addr2;
    logic [9:0] rom_data2;
    logic [8:0] lcd_word2;
    logic       lcd_dc2, lcd_rst_n2, busy2, init_done2;

    logic [9:0] rom  [64];
    logic [9:0] rom2 [4];

    always @(posedge clk) begin
        rom_data  <= rom[rom_addr];
        rom_data2 <= rom2[rom_addr2];
    end

    lcd_init_seq #(.ROM_AW(6), .MS_CYC(MS), .RST_LO_MS(2), .RST_WAIT_MS(3)) u_dut (
        .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
        .lcd_word(lcd_word), .lcd_dc(lcd_dc), .lcd_rst_n(lcd_rst_n), .busy(busy),
        .init_done(init_done)
    );

    lcd_init_seq #(.ROM_AW(2), .MS_CYC(MS), .RST_LO_MS(2), .RST_WAIT_MS(3)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .rom_addr(rom_addr2), .rom_data(rom_data2),
        .lcd_word(lcd_word2), .lcd_dc(lcd_dc2), .lcd_rst_n(lcd_rst_n2), .busy(busy2),
        .init_done(init_done2)
    );

    // ---------------- monitors (sample on the falling edge) ----------------
    int         cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       mon_clr = 1'b1;
    int         n_wr, rise_cnt, stab_err, fall_cyc, first_fall_cyc, rst_low_len, rst_rise_cyc;
    logic [8:0] wr_cap  [8];
    int         low_len [8];
    int         rise_cyc[8];
    logic       prev_wr = 1'b1, prev_rst = 1'b1, prev_dc = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (mon_clr) begin
            n_wr = 0; rise_cnt = 0; stab_err = 0; fall_cyc = 0;
            first_fall_cyc = -1; rst_low_len = 0; rst_rise_cyc = -1;
        end else begin
            if (prev_wr && !lcd_word[8]) begin
                if (n_wr < 8) wr_cap[n_wr] = {lcd_dc, lcd_word[7:0]};
                if (first_fall_cyc < 0) first_fall_cyc = cyc;
                fall_cyc = cyc;
                n_wr++;
            end else if (!prev_wr && !lcd_word[8] &&
                         (lcd_dc != prev_dc || lcd_word[7:0] != prev_data)) begin
                stab_err++;
            end
            if (!prev_wr && lcd_word[8]) begin
                if (rise_cnt < 8) begin
                    low_len[rise_cnt]  = cyc - fall_cyc;
                    rise_cyc[rise_cnt] = cyc;
                end
                rise_cnt++;
            end
            if (!lcd_rst_n) rst_low_len++;
            if (!prev_rst && lcd_rst_n) rst_rise_cyc = cyc;
        end
        prev_wr = lcd_word[8]; prev_dc = lcd_dc; prev_data = lcd_word[7:0]; prev_rst = lcd_rst_n;
    end

    int         n_wr2, addr0_err;
    logic [7:0] last2;
    logic       seen_nz = 1'b0, prev_wr2 = 1'b1;
    always @(negedge clk) begin
        if (mon_clr) begin
            n_wr2 = 0; addr0_err = 0; seen_nz = 1'b0; last2 = 8'h00;
        end else begin
            if (prev_wr2 && !lcd_word2[8]) begin
                n_wr2++;
                last2 = lcd_word2[7:0];
            end
            if (busy2 && rom_addr2 != 2'd0) seen_nz = 1'b1;
            if (busy2 && seen_nz && rom_addr2 == 2'd0) addr0_err++;
        end
        prev_wr2 = lcd_word2[8];
    end

    // ---------------- checking helpers ----------------
    int n_chk = 0, n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            if (init_done && !busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic load_rom(input logic [3:0][9:0] prog);
        for (int a = 0; a < 64; a++) rom[a] = (a < 4) ? prog[a] : 10'h300;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0][9:0] prog;    // prog[0] is address 0
        int              n_wr;    // expected WR pulses
        int              w0, w1;  // expected {dc,data} of first two writes
        int              gap;     // clocks between first two WR rising edges
    } vec_t;

    function automatic vec_t mk(input logic [9:0] r0, r1, r2, r3,
                                input int n, a, b, g);
        vec_t v;
        v.prog = {r3, r2, r1, r0};
        v.n_wr = n; v.w0 = a; v.w1 = b; v.gap = g;
        return v;
    endfunction

    vec_t vecs[5];
    bit   ok;

    initial begin
        vecs[0] = mk(10'h011, 10'h155, 10'h300, 10'h300, 2, 'h011, 'h155, 10);
        vecs[1] = mk(10'h029, 10'h203, 10'h02C, 10'h300, 2, 'h029, 'h02C, 3 * MS + 13);
        vecs[2] = mk(10'h029, 10'h200, 10'h02C, 10'h300, 2, 'h029, 'h02C, 13);
        vecs[3] = mk(10'h1A5, 10'h03C, 10'h100, 10'h300, 3, 'h1A5, 'h03C, 10);
        vecs[4] = mk(10'h300, 10'h011, 10'h011, 10'h300, 0, 0, 0, 0);
        for (int a = 0; a < 4; a++) rom2[a] = 10'(a + 1);

        reset = 1'b1; start = 1'b0; start2 = 1'b0;
        load_rom(vecs[0].prog);
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_word", lcd_word, 'h100);
        check("rst_dc", lcd_dc, 0);
        check("rst_rst_n", lcd_rst_n, 1);
        check("rst_addr", rom_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_init_done", init_done, 0);
        reset = 1'b0;
        clear_mon();

        // Start latency: start sampled at edge n
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("lat_busy_n", busy, 1);
        check("lat_wr_n", lcd_word[8], 1);
`ifndef LCD_HWRST_EN
        @(posedge clk); #1;
        check("lat_wr_n1", lcd_word[8], 1);
        @(posedge clk); #1;
        check("lat_wr_n2", lcd_word[8], 0);
        check("lat_data_n2", lcd_word[7:0], 'h11);
`else
        check("lat_rst_n", lcd_rst_n, 0);
`endif
        @(negedge clk);
        wait_done(ok);
        check("lat_timeout", ok, 1);
        $display("latency run: writes=%0d", n_wr);

        // Table-driven programs
        for (int v = 0; v < 5; v++) begin
            load_rom(vecs[v].prog);
            clear_mon();
            pulse_start();
            wait_done(ok);
            check("vec_timeout", ok, 1);
            check("vec_nwr", n_wr, vecs[v].n_wr);
            if (vecs[v].n_wr >= 1) check("vec_w0", wr_cap[0], vecs[v].w0);
            if (vecs[v].n_wr >= 2) begin
                check("vec_w1", wr_cap[1], vecs[v].w1);
                check("vec_gap", rise_cyc[1] - rise_cyc[0], vecs[v].gap);
            end
            for (int i = 0; i < n_wr && i < 8; i++) check("vec_wr_lo_len", low_len[i], 4);
            check("vec_stable", stab_err, 0);
            check("vec_idle_word", lcd_word, 'h100);
            check("vec_busy", busy, 0);
            check("vec_init_done", init_done, 1);
`ifdef LCD_HWRST_EN
            check("vec_rst_lo_len", rst_low_len, 2 * MS);
            if (vecs[v].n_wr >= 1)
                check("vec_rst_to_wr", first_fall_cyc - rst_rise_cyc, 3 * MS + 2);
`else
            check("vec_rst_n_high", rst_low_len, 0);
`endif
            $display("vec %0d: writes=%0d gap=%0d", v, n_wr,
                     (n_wr >= 2) ? rise_cyc[1] - rise_cyc[0] : 0);
        end

        // Reset during WR_LO of the second byte, then replay from address 0
        load_rom(vecs[0].prog);
        clear_mon();
        pulse_start();
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (n_wr == 2) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("abort_reach_byte2", ok, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_word", lcd_word, 'h100);
        check("abort_busy", busy, 0);
        check("abort_init_done", init_done, 0);
        @(negedge clk);
        reset = 1'b0;
        clear_mon();
        pulse_start();
        wait_done(ok);
        check("replay_timeout", ok, 1);
        check("replay_nwr", n_wr, 2);
        check("replay_w0", wr_cap[0], 'h011);
        $display("abort/replay: writes=%0d", n_wr);

        // start while busy is ignored
        clear_mon();
        pulse_start();
        repeat (5) @(negedge clk);
        pulse_start();
        repeat (12) @(negedge clk);
        pulse_start();
        wait_done(ok);
        check("busy_start_timeout", ok, 1);
        check("busy_start_nwr", n_wr, 2);
        $display("start-while-busy: writes=%0d", n_wr);

        // start in DONE replays the full sequence
        clear_mon();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_restart_init_done", init_done, 0);
        check("done_restart_busy", busy, 1);
        @(negedge clk);
        wait_done(ok);
        check("done_restart_timeout", ok, 1);
        check("done_restart_nwr", n_wr, 2);
        $display("restart from DONE: writes=%0d", n_wr);

        // 4-entry ROM with no END: implicit END at the last address
        clear_mon();
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (init_done2 && !busy2) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("noend_timeout", ok, 1);
        check("noend_nwr", n_wr2, 4);
        check("noend_last_data", last2, 'h04);
        check("noend_addr_wrap", addr0_err, 0);
        check("noend_word", lcd_word2, 'h100);
        $display("no-END ROM: writes=%0d", n_wr2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
